// File: rtl/req_cxt_fetch_mux.sv
// Round-robin mux of per-channel sub-WQE slots into credit-limited CXT_READ requests; REQ_CXT_FETCH_SEQ_TAG_EN prepends an 8-bit sequence tag.
// Latency: input handshake at edge N, request valid after edge N+1 at the earliest; one request per cycle sustained.
// Backpressure: a held output freezes head/data; sub_wqe_ready comes only from slot occupancy, never from downstream ready.
module req_cxt_fetch_mux #(
    parameter int         CHANNEL_NUM       = 4,
    parameter int         META_WIDTH        = 384,
    parameter int         QPN_WIDTH         = 16,
    parameter int         QUEUE_INDEX_WIDTH = 14,
    parameter int         SLOT_CNT_WIDTH    = 3,
    parameter logic [3:0] CXT_READ_OPCODE   = 4'h1,
    parameter int         CREDIT_MAX        = 8,
    localparam int CH_LOG      = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1,
    localparam int BASE_HEAD_W = CH_LOG + QPN_WIDTH + 4 + 1 + SLOT_CNT_WIDTH + QUEUE_INDEX_WIDTH,
`ifdef REQ_CXT_FETCH_SEQ_TAG_EN
    localparam int HEAD_W      = BASE_HEAD_W + 8
`else
    localparam int HEAD_W      = BASE_HEAD_W
`endif
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CHANNEL_NUM-1:0]            sub_wqe_valid,
    input  logic [CHANNEL_NUM*META_WIDTH-1:0] sub_wqe_meta,
    output logic [CHANNEL_NUM-1:0]            sub_wqe_ready,
    output logic                              fetch_cxt_ingress_valid,
    output logic [HEAD_W-1:0]                 fetch_cxt_ingress_head,
    output logic [META_WIDTH-1:0]             fetch_cxt_ingress_data,
    output logic                              fetch_cxt_ingress_start,
    output logic                              fetch_cxt_ingress_last,
    input  logic                              fetch_cxt_ingress_ready,
    input  logic                              credit_return,
    output logic [7:0]                        credit_avail
);

    typedef struct packed {
        logic [CH_LOG-1:0]            channel_id;
        logic [QPN_WIDTH-1:0]         qpn;
        logic [3:0]                   opcode;
        logic                         bypass;
        logic [SLOT_CNT_WIDTH-1:0]    slot_count;
        logic [QUEUE_INDEX_WIDTH-1:0] queue_index;
    } hdr_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    logic [CHANNEL_NUM-1:0] slot_full;
    logic [META_WIDTH-1:0]  slot_meta [CHANNEL_NUM];
    logic [CHANNEL_NUM-1:0] slot_load;
    logic                   ready_en;

    logic [CH_LOG-1:0]      rr_ptr;
    logic [CH_LOG-1:0]      gnt_idx;
    logic                   gnt_found;
    int                     arb_idx;

    out_state_t             state;
    out_state_t             state_nxt;
    logic                   load;

    logic [7:0]             credit;
    logic [7:0]             credit_nxt;
    logic [8:0]             credit_sum;

    hdr_t                   hdr_nxt;
    logic [HEAD_W-1:0]      head_q;
    logic [META_WIDTH-1:0]  data_q;

`ifdef REQ_CXT_FETCH_SEQ_TAG_EN
    logic [7:0]             seq_tag;
`endif

    // ready_en keeps every channel closed while rst is high and for the edge it is released on
    assign sub_wqe_ready = ~slot_full & {CHANNEL_NUM{ready_en}};
    assign slot_load     = sub_wqe_valid & sub_wqe_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full <= '0;
            ready_en  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                if (load && (gnt_idx == CH_LOG'(i))) begin
                    slot_full[i] <= 1'b0;
                end else if (slot_load[i]) begin
                    slot_full[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (slot_load[i]) begin
                slot_meta[i] <= sub_wqe_meta[i*META_WIDTH +: META_WIDTH];
            end
        end
    end

    // First full slot at or after rr_ptr, scanning cyclically
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        arb_idx   = 0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            arb_idx = int'(rr_ptr) + k;
            if (arb_idx >= CHANNEL_NUM) begin
                arb_idx = arb_idx - CHANNEL_NUM;
            end
            if (!gnt_found && slot_full[CH_LOG'(arb_idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_LOG'(arb_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OUT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // credit already reflects the beat being drained, so a back-to-back reload
    // needs credit left over or a return landing on the same edge
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            OUT_EMPTY: begin
                if (gnt_found && (credit != 8'd0)) begin
                    load      = 1'b1;
                    state_nxt = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (fetch_cxt_ingress_ready) begin
                    if (gnt_found && ((credit != 8'd0) || credit_return)) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = OUT_EMPTY;
                    end
                end
            end
            default: state_nxt = OUT_EMPTY;
        endcase
    end

    always_comb begin
        credit_sum = {1'b0, credit} + {8'd0, credit_return} - {8'd0, load};
        if (credit_sum > 9'(CREDIT_MAX)) begin
            credit_nxt = 8'(CREDIT_MAX);
        end else begin
            credit_nxt = credit_sum[7:0];
        end
    end

    always_comb begin
        hdr_nxt.channel_id  = gnt_idx;
        hdr_nxt.qpn         = slot_meta[gnt_idx][QPN_WIDTH-1:0];
        hdr_nxt.opcode      = CXT_READ_OPCODE;
        hdr_nxt.bypass      = 1'b0;
        hdr_nxt.slot_count  = SLOT_CNT_WIDTH'(1);
        hdr_nxt.queue_index = QUEUE_INDEX_WIDTH'(slot_meta[gnt_idx][QPN_WIDTH-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit <= 8'(CREDIT_MAX);
            rr_ptr <= '0;
            head_q <= '0;
            data_q <= '0;
        end else begin
            credit <= credit_nxt;
            if (load) begin
`ifdef REQ_CXT_FETCH_SEQ_TAG_EN
                head_q <= {seq_tag, hdr_nxt};
`else
                head_q <= hdr_nxt;
`endif
                data_q <= slot_meta[gnt_idx];
                rr_ptr <= (int'(gnt_idx) == CHANNEL_NUM - 1) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

`ifdef REQ_CXT_FETCH_SEQ_TAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_tag <= 8'd0;
        end else if (load) begin
            seq_tag <= seq_tag + 8'd1;
        end
    end
`endif

    assign fetch_cxt_ingress_valid = (state == OUT_FULL);
    assign fetch_cxt_ingress_start = fetch_cxt_ingress_valid;
    assign fetch_cxt_ingress_last  = fetch_cxt_ingress_valid;
    assign fetch_cxt_ingress_head  = head_q;
    assign fetch_cxt_ingress_data  = data_q;
    assign credit_avail            = credit;

endmodule
